psg_bus_ctrl: RTL and testbench



---
 rtl/psg_pkg.sv | 75 +++++++
 rtl/psg_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_psg_bus_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// -----------------------------------------------------------------------------
// psg_pkg
// Shared definitions for the PSG CPU-side bus controller:
//   - bus_mode_e  : decode of {bdir,bc1}
//   - bus_state_e : registered copy of the bus mode
//   - R_* constants: register file indices R0..R15
//   - W_* constants: implemented bit width of each register class
//   - reg_mask()  : clears the unimplemented bits of a register value
// -----------------------------------------------------------------------------
package psg_pkg;

  localparam int NUM_REGS = 16;

  // {bdir,bc1} bus cycle encodings
  typedef enum logic [1:0] {
    MODE_INACTIVE = 2'b00,
    MODE_READ     = 2'b01,
    MODE_WRITE    = 2'b10,
    MODE_LATCH    = 2'b11
  } bus_mode_e;

  // Same encodings as bus_mode_e so the state is a direct copy of the mode
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_LATCH = 2'b11
  } bus_state_e;

  // Register indices
  localparam logic [3:0] R_TONE_A_LO = 4'd0;
  localparam logic [3:0] R_TONE_A_HI = 4'd1;
  localparam logic [3:0] R_TONE_B_LO = 4'd2;
  localparam logic [3:0] R_TONE_B_HI = 4'd3;
  localparam logic [3:0] R_TONE_C_LO = 4'd4;
  localparam logic [3:0] R_TONE_C_HI = 4'd5;
  localparam logic [3:0] R_NOISE     = 4'd6;
  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_AMP_A     = 4'd8;
  localparam logic [3:0] R_AMP_B     = 4'd9;
  localparam logic [3:0] R_AMP_C     = 4'd10;
  localparam logic [3:0] R_ENV_LO    = 4'd11;
  localparam logic [3:0] R_ENV_HI    = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_IO_A      = 4'd14;
  localparam logic [3:0] R_IO_B      = 4'd15;

  // Implemented widths per register class
  localparam int W_TONE_HI   = 4;
  localparam int W_NOISE     = 5;
  localparam int W_AMP       = 5;
  localparam int W_ENV_SHAPE = 4;
  localparam int W_FULL      = 8;

  localparam logic [7:0] MASK_TONE_HI   = 8'((1 << W_TONE_HI) - 1);
  localparam logic [7:0] MASK_NOISE     = 8'((1 << W_NOISE) - 1);
  localparam logic [7:0] MASK_AMP       = 8'((1 << W_AMP) - 1);
  localparam logic [7:0] MASK_ENV_SHAPE = 8'((1 << W_ENV_SHAPE) - 1);
  localparam logic [7:0] MASK_FULL      = 8'((1 << W_FULL) - 1);

  // Unimplemented bits are stored and read back as zero.
  function automatic logic [7:0] reg_mask(input logic [3:0] addr,
                                          input logic [7:0] data);
    logic [7:0] m;
    case (addr)
      R_TONE_A_HI, R_TONE_B_HI, R_TONE_C_HI: m = MASK_TONE_HI;
      R_ENV_SHAPE:                           m = MASK_ENV_SHAPE;
      R_NOISE:                               m = MASK_NOISE;
      R_AMP_A, R_AMP_B, R_AMP_C:             m = MASK_AMP;
      default:                               m = MASK_FULL;
    endcase
    return data & m;
  endfunction

endpackage

// File: rtl/psg_bus_ctrl.sv
// -----------------------------------------------------------------------------
// psg_bus_ctrl
// CPU-side bus controller for the PSG core. Decodes AY-3-8910 style BDIR/BC1
// bus cycles, latches the register address, commits writes into the 16-entry
// register file on the trailing edge of a WRITE, and serves registered reads.
// All config outputs are wired straight from the register file.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   bdir, bc1            bus control (already synchronous to clk)
//   data_in              CPU data/address bus
//   data_out, data_oe    registered read data and its drive enable
//   tone_*_period        12-bit tone periods from R0..R5
//   noise_period         R6[4:0]
//   mixer                R7
//   amp_a/b/c            R8..R10 [4:0]
//   env_period           {R12,R11}
//   env_shape            R13[3:0]
//   env_restart          one-cycle pulse the cycle after an R13 commit
//   io_a, io_b           R14, R15
// -----------------------------------------------------------------------------
module psg_bus_ctrl
  import psg_pkg::*;
#(
  parameter logic [3:0] CHIP_ADDR = 4'h0,
  parameter int         DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bdir,
  input  logic                 bc1,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_oe,
  output logic [11:0]          tone_a_period,
  output logic [11:0]          tone_b_period,
  output logic [11:0]          tone_c_period,
  output logic [4:0]           noise_period,
  output logic [7:0]           mixer,
  output logic [4:0]           amp_a,
  output logic [4:0]           amp_b,
  output logic [4:0]           amp_c,
  output logic [15:0]          env_period,
  output logic [3:0]           env_shape,
  output logic                 env_restart,
  output logic [7:0]           io_a,
  output logic [7:0]           io_b
);

  bus_mode_e  mode;
  bus_state_e state_reg;
  logic [3:0] addr_reg;
  logic       sel_reg;
  logic [7:0] wdata_reg;
  logic [7:0] data_out_reg;
  logic       data_oe_reg;
  logic       env_restart_reg;
  logic       commit;

  logic [7:0]          regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;

  assign mode = bus_mode_e'({bdir, bc1});

  // A write lands when the bus leaves WRITE. addr_reg is still the pre-latch
  // value here even if this same cycle is a LATCH.
  assign commit = (state_reg == ST_WRITE) && (mode != MODE_WRITE) && sel_reg;

  // ---------------------------------------------------------------------------
  // Bus FSM with registered read port and restart pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      sel_reg         <= 1'b0;
      wdata_reg       <= '0;
      data_out_reg    <= '0;
      data_oe_reg     <= 1'b0;
      env_restart_reg <= 1'b0;
    end else begin
      // State tracks the mode every cycle; any-to-any is legal.
      state_reg <= bus_state_e'(mode);

      if (mode == MODE_LATCH) begin
        addr_reg <= data_in[3:0];
        sel_reg  <= (data_in[7:4] == CHIP_ADDR);
      end

      if (mode == MODE_WRITE) begin
        wdata_reg <= data_in[7:0];
      end

      // Read uses the register value before any commit in this same cycle,
      // so WRITE->READ returns the old value first.
      if ((mode == MODE_READ) && sel_reg) begin
        data_oe_reg  <= 1'b1;
        data_out_reg <= reg_mask(addr_reg, regs_reg[addr_reg]);
      end else begin
        data_oe_reg  <= 1'b0;
        data_out_reg <= '0;
      end

      env_restart_reg <= commit && (addr_reg == R_ENV_SHAPE);
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: one write enable per entry, values stored pre-masked
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
    assign wr_en[gi] = commit && (addr_reg == 4'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs_reg[i] <= '0;
      end else if (wr_en[i]) begin
        regs_reg[i] <= reg_mask(4'(i), wdata_reg);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign data_out    = DATA_BITS'(data_out_reg);
  assign data_oe     = data_oe_reg;
  assign env_restart = env_restart_reg;

  assign tone_a_period = {regs_reg[R_TONE_A_HI][3:0], regs_reg[R_TONE_A_LO]};
  assign tone_b_period = {regs_reg[R_TONE_B_HI][3:0], regs_reg[R_TONE_B_LO]};
  assign tone_c_period = {regs_reg[R_TONE_C_HI][3:0], regs_reg[R_TONE_C_LO]};
  assign noise_period  = regs_reg[R_NOISE][4:0];
  assign mixer         = regs_reg[R_MIXER];
  assign amp_a         = regs_reg[R_AMP_A][4:0];
  assign amp_b         = regs_reg[R_AMP_B][4:0];
  assign amp_c         = regs_reg[R_AMP_C][4:0];
  assign env_period    = {regs_reg[R_ENV_HI], regs_reg[R_ENV_LO]};
  assign env_shape     = regs_reg[R_ENV_SHAPE][3:0];
  assign io_a          = regs_reg[R_IO_A];
  assign io_b          = regs_reg[R_IO_B];

endmodule

// File: tb/tb_psg_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_psg_bus_ctrl
// Directed bus-cycle sequences against psg_bus_ctrl with hand-computed
// expected values. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_psg_bus_ctrl;

  localparam logic [1:0] M_INACT = 2'b00;
  localparam logic [1:0] M_READ  = 2'b01;
  localparam logic [1:0] M_WRITE = 2'b10;
  localparam logic [1:0] M_LATCH = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bdir = 1'b0;
  logic        bc1 = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [11:0] tone_a_period, tone_b_period, tone_c_period;
  logic [4:0]  noise_period;
  logic [7:0]  mixer;
  logic [4:0]  amp_a, amp_b, amp_c;
  logic [15:0] env_period;
  logic [3:0]  env_shape;
  logic        env_restart;
  logic [7:0]  io_a, io_b;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int pulse_base;

  psg_bus_ctrl #(.CHIP_ADDR(4'h0), .DATA_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bdir         (bdir),
    .bc1          (bc1),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .tone_a_period(tone_a_period),
    .tone_b_period(tone_b_period),
    .tone_c_period(tone_c_period),
    .noise_period (noise_period),
    .mixer        (mixer),
    .amp_a        (amp_a),
    .amp_b        (amp_b),
    .amp_c        (amp_c),
    .env_period   (env_period),
    .env_shape    (env_shape),
    .env_restart  (env_restart),
    .io_a         (io_a),
    .io_b         (io_b)
  );

  always #5 clk = ~clk;

  // Count restart pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (env_restart === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drive one bus mode for n cycles; returns 1 unit after the last edge.
  task automatic bus(input logic [1:0] m, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      {bdir, bc1} = m;
      data_in     = d;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1;
    bus(M_INACT, 8'h00, 2);
    reset = 1'b0;
    check("rst data_oe", 32'(data_oe), 32'h0);
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst env_restart", 32'(env_restart), 32'h0);
    check("rst tone_a", 32'(tone_a_period), 32'h0);
    check("rst mixer", 32'(mixer), 32'h0);

    // ---------------- R6 noise, 5-bit mask ----------------
    bus(M_LATCH, 8'h06, 1);
    bus(M_WRITE, 8'hFF, 2);
    check("noise before commit", 32'(noise_period), 32'h0);
    bus(M_INACT, 8'h00, 1);
    check("noise after commit", 32'(noise_period), 32'h1F);
    bus(M_READ, 8'h00, 1);
    check("R6 read data_oe", 32'(data_oe), 32'h1);
    check("R6 read data_out", 32'(data_out), 32'h1F);
    bus(M_INACT, 8'h00, 1);
    check("read end data_oe", 32'(data_oe), 32'h0);
    check("read end data_out", 32'(data_out), 32'h0);

    // ---------------- tone A, WRITE->LATCH ----------------
    bus(M_LATCH, 8'h00, 1);
    bus(M_WRITE, 8'hA5, 1);
    bus(M_LATCH, 8'h01, 1);
    bus(M_WRITE, 8'hF3, 1);
    bus(M_INACT, 8'h00, 1);
    check("tone_a", 32'(tone_a_period), 32'h3A5);
    bus(M_READ, 8'h00, 1);
    check("R1 read", 32'(data_out), 32'h03);

    // ---------------- env shape + restart pulses ----------------
    pulse_base = pulse_cnt;
    bus(M_LATCH, 8'h0D, 1);
    bus(M_WRITE, 8'h0A, 1);
    bus(M_INACT, 8'h00, 1);
    check("env_shape", 32'(env_shape), 32'hA);
    check("env_restart pulse1", 32'(env_restart), 32'h1);
    bus(M_INACT, 8'h00, 1);
    check("env_restart low1", 32'(env_restart), 32'h0);
    bus(M_WRITE, 8'h0A, 1);
    bus(M_INACT, 8'h00, 1);
    check("env_restart pulse2", 32'(env_restart), 32'h1);
    bus(M_INACT, 8'h00, 2);
    check("env_restart low2", 32'(env_restart), 32'h0);
    check("env_restart count", 32'(pulse_cnt - pulse_base), 32'd2);

    // ---------------- unselected chip ----------------
    bus(M_LATCH, 8'h17, 1);
    bus(M_WRITE, 8'h55, 1);
    bus(M_INACT, 8'h00, 1);
    check("unsel mixer", 32'(mixer), 32'h00);
    bus(M_READ, 8'h00, 1);
    check("unsel data_oe", 32'(data_oe), 32'h0);
    check("unsel data_out", 32'(data_out), 32'h0);
    bus(M_LATCH, 8'h07, 1);
    bus(M_READ, 8'h00, 1);
    check("R7 sel data_oe", 32'(data_oe), 32'h1);
    check("R7 sel data_out", 32'(data_out), 32'h00);

    // ---------------- reset during WRITE ----------------
    bus(M_LATCH, 8'h08, 1);
    bus(M_WRITE, 8'h1F, 1);
    reset = 1'b1;
    bus(M_WRITE, 8'h1F, 1);
    reset = 1'b0;
    bus(M_INACT, 8'h00, 1);
    check("rst-wr amp_a", 32'(amp_a), 32'h0);
    bus(M_INACT, 8'h00, 1);
    check("rst-wr amp_a later", 32'(amp_a), 32'h0);
    check("rst-wr noise cleared", 32'(noise_period), 32'h0);
    check("rst-wr tone_a cleared", 32'(tone_a_period), 32'h0);

    // ---------------- R9 then direct LATCH ----------------
    bus(M_LATCH, 8'h09, 1);
    bus(M_WRITE, 8'h0C, 1);
    bus(M_LATCH, 8'h0A, 1);
    check("amp_b", 32'(amp_b), 32'h0C);
    check("amp_c untouched", 32'(amp_c), 32'h0);

    // ---------------- WRITE->READ: old value then new ----------------
    bus(M_WRITE, 8'hE7, 1);
    bus(M_READ, 8'h00, 1);
    check("wr->rd old value", 32'(data_out), 32'h00);
    check("amp_c masked", 32'(amp_c), 32'h07);
    bus(M_READ, 8'h00, 1);
    check("wr->rd new value", 32'(data_out), 32'h07);

    // ---------------- env period and IO regs ----------------
    bus(M_LATCH, 8'h0B, 1);
    bus(M_WRITE, 8'h34, 1);
    bus(M_LATCH, 8'h0C, 1);
    bus(M_WRITE, 8'h12, 1);
    bus(M_LATCH, 8'h0E, 1);
    bus(M_WRITE, 8'hC3, 1);
    bus(M_LATCH, 8'h0F, 1);
    bus(M_WRITE, 8'h5A, 1);
    bus(M_INACT, 8'h00, 1);
    check("env_period", 32'(env_period), 32'h1234);
    check("io_a", 32'(io_a), 32'hC3);
    check("io_b", 32'(io_b), 32'h5A);
    check("env_restart quiet", 32'(pulse_cnt - pulse_base), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
